// File: rtl/bresenham_line_scorer.sv
// Walks an all-octant Bresenham line over the residual image, scoring the pixels
// under a candidate string and, in draw/erase modes, updating them in place.
module bresenham_line_scorer #(
  parameter int COORD_W = 9,
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 320,
  parameter int ADDR_W  = 17,
  parameter int PIX_W   = 8,
  parameter int ACC_W   = 19,
  parameter int LINE_W  = 32,
  parameter int THRESH  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [COORD_W-1:0] req_x0,
  input  logic [COORD_W-1:0] req_y0,
  input  logic [COORD_W-1:0] req_x1,
  input  logic [COORD_W-1:0] req_y1,
  input  logic [1:0]         req_mode,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [ACC_W-1:0]   resp_reduction,
  output logic [COORD_W:0]   resp_count,
  output logic               resp_err,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_ren,
  input  logic [PIX_W-1:0]   mem_rdata,
  output logic               mem_wen,
  output logic [PIX_W-1:0]   mem_wdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_RD, S_WR, S_DRAIN, S_RESP
  } state_t;

  localparam int EW = COORD_W + 2;
  localparam logic [COORD_W-1:0] C_ONE      = COORD_W'(1);
  localparam logic [COORD_W:0]   CNT_ONE    = (COORD_W+1)'(1);
  localparam logic [COORD_W:0]   X_LIM      = (COORD_W+1)'(IMG_W);
  localparam logic [COORD_W:0]   Y_LIM      = (COORD_W+1)'(IMG_H);
  localparam logic [ADDR_W-1:0]  ROW_STRIDE = ADDR_W'(IMG_W);
  localparam logic [PIX_W-1:0]   LINE_PIX   = PIX_W'(LINE_W);
  localparam logic [ACC_W-1:0]   THRESH_EXT = ACC_W'(THRESH);

  state_t state, state_next;

  logic [1:0]            mode;
  logic [COORD_W-1:0]    x, y, x1, y1;
  logic [COORD_W-1:0]    dx, dy, dx_calc, dy_calc;
  logic                  sx_neg, sy_neg;
  logic signed [EW-1:0]  err, err_next, dx_e, dy_e;
  logic signed [EW:0]    e2, dx_w, dy_w;
  logic                  step, step_x, step_y;
  logic                  last, out_of_bounds, draw_mode, rd_pending;
  logic [ACC_W-1:0]      acc, acc_delta;
  logic [COORD_W:0]      count;
  logic                  err_flag;
  logic [ADDR_W-1:0]     pix_addr;
  logic [PIX_W:0]        pix_sum;
  logic [PIX_W-1:0]      pix_dif, wr_pix;

  always_comb begin
    dx_calc       = (x1 >= x) ? x1 - x : x - x1;
    dy_calc       = (y1 >= y) ? y1 - y : y - y1;
    out_of_bounds = ({1'b0, x} >= X_LIM) || ({1'b0, x1} >= X_LIM) ||
                    ({1'b0, y} >= Y_LIM) || ({1'b0, y1} >= Y_LIM);
    draw_mode     = (mode == 2'd1) || (mode == 2'd2);
    last          = (x == x1) && (y == y1);
    pix_addr      = ADDR_W'(y) * ROW_STRIDE + ADDR_W'(x);
  end

  // Bresenham step decision; both updates use the error from before this step
  always_comb begin
    dx_e   = {2'b00, dx};
    dy_e   = {2'b00, dy};
    dx_w   = {3'b000, dx};
    dy_w   = {3'b000, dy};
    e2     = {err, 1'b0};
    step_x = e2 > -dy_w;
    step_y = e2 < dx_w;
    err_next = err;
    if (step_x) err_next = err_next - dy_e;
    if (step_y) err_next = err_next + dx_e;
  end

  always_comb begin
    pix_sum = {1'b0, mem_rdata} + {1'b0, LINE_PIX};
    pix_dif = mem_rdata - LINE_PIX;
    if (mode == 2'd2)
      wr_pix = pix_sum[PIX_W] ? '1 : pix_sum[PIX_W-1:0];
    else
      wr_pix = (mem_rdata >= LINE_PIX) ? pix_dif : '0;
    case (mode)
      2'd2:    acc_delta = -ACC_W'(mem_rdata);
      2'd3:    acc_delta = ACC_W'(mem_rdata) - THRESH_EXT;
      default: acc_delta = ACC_W'(mem_rdata);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Draw/erase alternate read and write of each pixel; scoring streams reads
  always_comb begin
    state_next = state;
    req_rdy    = 1'b0;
    resp_val   = 1'b0;
    mem_ren    = 1'b0;
    mem_wen    = 1'b0;
    step       = 1'b0;
    case (state)
      S_IDLE: begin
        req_rdy = 1'b1;
        if (req_val) state_next = S_SETUP;
      end
      S_SETUP: state_next = out_of_bounds ? S_RESP : S_RD;
      S_RD: begin
        mem_ren = 1'b1;
        if (draw_mode)  state_next = S_WR;
        else if (last)  state_next = S_DRAIN;
        else            step = 1'b1;
      end
      S_WR: begin
        mem_wen = 1'b1;
        if (last) begin
          state_next = S_RESP;
        end else begin
          step       = 1'b1;
          state_next = S_RD;
        end
      end
      S_DRAIN: state_next = S_RESP;
      S_RESP: begin
        resp_val = 1'b1;
        if (resp_rdy) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode       <= '0;
      x          <= '0;
      y          <= '0;
      x1         <= '0;
      y1         <= '0;
      dx         <= '0;
      dy         <= '0;
      sx_neg     <= 1'b0;
      sy_neg     <= 1'b0;
      err        <= '0;
      acc        <= '0;
      count      <= '0;
      err_flag   <= 1'b0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= mem_ren;
      if (state == S_IDLE && req_val) begin
        x    <= req_x0;
        y    <= req_y0;
        x1   <= req_x1;
        y1   <= req_y1;
        mode <= req_mode;
      end
      if (state == S_SETUP) begin
        dx       <= dx_calc;
        dy       <= dy_calc;
        sx_neg   <= x1 < x;
        sy_neg   <= y1 < y;
        err      <= $signed({2'b00, dx_calc}) - $signed({2'b00, dy_calc});
        acc      <= '0;
        count    <= '0;
        err_flag <= out_of_bounds;
      end
      if (mem_ren)    count <= count + CNT_ONE;
      if (rd_pending) acc   <= acc + acc_delta;
      if (step) begin
        err <= err_next;
        if (step_x) x <= sx_neg ? x - C_ONE : x + C_ONE;
        if (step_y) y <= sy_neg ? y - C_ONE : y + C_ONE;
      end
    end
  end

  assign mem_addr       = (mem_ren || mem_wen) ? pix_addr : '0;
  assign mem_wdata      = mem_wen ? wr_pix : '0;
  assign resp_reduction = acc;
  assign resp_count     = count;
  assign resp_err       = err_flag;

endmodule

// File: tb/tb_bresenham_line_scorer.sv
// Directed bench for bresenham_line_scorer against a behavioural residual RAM
// with one-cycle read latency.
module tb_bresenham_line_scorer;

  localparam int COORD_W  = 9;
  localparam int IMG_W    = 320;
  localparam int IMG_H    = 320;
  localparam int ADDR_W   = 17;
  localparam int PIX_W    = 8;
  localparam int ACC_W    = 19;
  localparam int MEM_SIZE = IMG_W * IMG_H;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               req_val = 1'b0;
  logic               req_rdy;
  logic [COORD_W-1:0] req_x0 = '0, req_y0 = '0, req_x1 = '0, req_y1 = '0;
  logic [1:0]         req_mode = '0;
  logic               resp_val;
  logic               resp_rdy = 1'b0;
  logic [ACC_W-1:0]   resp_reduction;
  logic [COORD_W:0]   resp_count;
  logic               resp_err;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ren;
  logic [PIX_W-1:0]   mem_rdata;
  logic               mem_wen;
  logic [PIX_W-1:0]   mem_wdata;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  bresenham_line_scorer dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .req_mode(req_mode),
    .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_reduction(resp_reduction), .resp_count(resp_count), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata)
  );

  logic [PIX_W-1:0] mem [MEM_SIZE];
  logic [PIX_W-1:0] rdata_q = '0;
  assign mem_rdata = rdata_q;

  always @(posedge clk) begin
    if (mem_wen && int'(mem_addr) < MEM_SIZE) mem[mem_addr] = mem_wdata;
    if (mem_ren && int'(mem_addr) < MEM_SIZE) rdata_q <= mem[mem_addr];
  end

  // Observation: cycle k of a transaction is the clock period ending at accept edge + k
  int edge_cnt = 0;
  int accept_edge = 0;
  int hs_edge = 0;
  int first_resp_cycle, first_ren_cycle;
  int ren_cnt, wen_cnt, overlap_cnt, last_ren_addr;
  bit seen [int];
  int wr_addr_q [$];
  int wr_data_q [$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    if (req_val && req_rdy) accept_edge = edge_cnt + 1;
    if (mem_ren) begin
      ren_cnt++;
      seen[int'(mem_addr)] = 1'b1;
      last_ren_addr = int'(mem_addr);
      if (first_ren_cycle < 0) first_ren_cycle = edge_cnt + 1 - accept_edge;
    end
    if (mem_wen) begin
      wen_cnt++;
      wr_addr_q.push_back(int'(mem_addr));
      wr_data_q.push_back(int'(mem_wdata));
    end
    if (mem_ren && mem_wen) overlap_cnt++;
    if (resp_val && first_resp_cycle < 0) first_resp_cycle = edge_cnt + 1 - accept_edge;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_stats();
    ren_cnt = 0;
    wen_cnt = 0;
    overlap_cnt = 0;
    first_resp_cycle = -1;
    first_ren_cycle = -1;
    last_ren_addr = -1;
    seen.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic fill_mem(input int value);
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = PIX_W'(value);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send_request(input int x0, input int y0, input int x1, input int y1,
                              input int mode);
    @(posedge clk); #1;
    clear_stats();
    req_x0   = COORD_W'(x0);
    req_y0   = COORD_W'(y0);
    req_x1   = COORD_W'(x1);
    req_y1   = COORD_W'(y1);
    req_mode = 2'(mode);
    req_val  = 1'b1;
    @(posedge clk); #1;
    req_val  = 1'b0;
  endtask

  task automatic wait_resp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (resp_val) got = 1'b1;
    end
  endtask

  task automatic handshake();
    @(posedge clk); #1;
    resp_rdy = 1'b1;
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    hs_edge  = edge_cnt;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests_run++;
    if (req_rdy !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL reset_req_rdy: got %b expected 1", req_rdy);
    end
    tests_run++;
    if (resp_val !== 1'b0 || mem_ren !== 1'b0 || mem_wen !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes: got val=%b ren=%b wen=%b expected all 0", resp_val, mem_ren, mem_wen);
    end
    tests_run++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      tests_failed++; $display("[TB] FAIL reset_mem_bus: got addr=%0d wdata=%0d expected 0", mem_addr, mem_wdata);
    end
    tests_run++;
    if (resp_reduction !== '0 || resp_count !== '0 || resp_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_resp: got red=%0d cnt=%0d err=%b expected 0", resp_reduction, resp_count, resp_err);
    end
  endtask

  task automatic test_score_diag();
    bit got;
    fill_mem(10);
    send_request(200, 100, 100, 150, 0);
    wait_resp(got);
    tests_run++;
    if (!got) begin tests_failed++; $display("[TB] FAIL diag_timeout: got no resp_val expected one"); do_reset(); return; end
    tests_run++;
    if (resp_count !== 10'd101) begin tests_failed++; $display("[TB] FAIL diag_count: got %0d expected 101", resp_count); end
    tests_run++;
    if (resp_reduction !== 19'd1010) begin tests_failed++; $display("[TB] FAIL diag_reduction: got %0d expected 1010", resp_reduction); end
    tests_run++;
    if (resp_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL diag_err: got %b expected 0", resp_err); end
    handshake();
    tests_run++;
    if (first_resp_cycle != 104) begin tests_failed++; $display("[TB] FAIL diag_resp_cycle: got %0d expected 104", first_resp_cycle); end
    tests_run++;
    if (first_ren_cycle != 2) begin tests_failed++; $display("[TB] FAIL diag_first_read: got %0d expected 2", first_ren_cycle); end
    tests_run++;
    if (seen.num() != 101 || ren_cnt != 101) begin
      tests_failed++; $display("[TB] FAIL diag_addresses: got distinct=%0d reads=%0d expected 101", seen.num(), ren_cnt);
    end
    tests_run++;
    if (last_ren_addr != 150 * 320 + 100) begin tests_failed++; $display("[TB] FAIL diag_last_addr: got %0d expected 48100", last_ren_addr); end
    tests_run++;
    if (wen_cnt != 0) begin tests_failed++; $display("[TB] FAIL diag_no_write: got %0d writes expected 0", wen_cnt); end
  endtask

  task automatic test_draw_point();
    bit got;
    fill_mem(20);
    send_request(5, 5, 5, 5, 1);
    wait_resp(got);
    tests_run++;
    if (!got) begin tests_failed++; $display("[TB] FAIL point_timeout: got no resp_val expected one"); do_reset(); return; end
    tests_run++;
    if (resp_count !== 10'd1 || resp_reduction !== 19'd20) begin
      tests_failed++; $display("[TB] FAIL point_resp: got cnt=%0d red=%0d expected 1/20", resp_count, resp_reduction);
    end
    handshake();
    tests_run++;
    if (first_resp_cycle != 4) begin tests_failed++; $display("[TB] FAIL point_resp_cycle: got %0d expected 4", first_resp_cycle); end
    tests_run++;
    if (wr_addr_q.size() != 1 || wr_addr_q[0] != 1605 || wr_data_q[0] != 0) begin
      tests_failed++; $display("[TB] FAIL point_write: got %0d writes expected one write of 0 at 1605", wr_addr_q.size());
    end
    tests_run++;
    if (mem[1605] !== 8'd0 || mem[1606] !== 8'd20) begin
      tests_failed++; $display("[TB] FAIL point_mem: got %0d/%0d expected 0/20", mem[1605], mem[1606]);
    end
  endtask

  task automatic test_erase_vertical();
    bit got;
    int bad;
    logic signed [ACC_W-1:0] red;
    fill_mem(250);
    send_request(7, 0, 7, 3, 2);
    wait_resp(got);
    tests_run++;
    if (!got) begin tests_failed++; $display("[TB] FAIL erase_timeout: got no resp_val expected one"); do_reset(); return; end
    red = resp_reduction;
    tests_run++;
    if (red !== -19'sd1000 || resp_count !== 10'd4) begin
      tests_failed++; $display("[TB] FAIL erase_resp: got red=%0d cnt=%0d expected -1000/4", red, resp_count);
    end
    handshake();
    bad = 0;
    for (int k = 0; k < wr_addr_q.size(); k++)
      if (wr_addr_q[k] != 7 + 320 * k || wr_data_q[k] != 255) bad++;
    tests_run++;
    if (wr_addr_q.size() != 4 || bad != 0) begin
      tests_failed++; $display("[TB] FAIL erase_writes: got %0d writes (%0d wrong) expected 4 of 255", wr_addr_q.size(), bad);
    end
    tests_run++;
    if (overlap_cnt != 0) begin tests_failed++; $display("[TB] FAIL erase_overlap: got %0d overlaps expected 0", overlap_cnt); end
    tests_run++;
    if (first_resp_cycle != 10) begin tests_failed++; $display("[TB] FAIL erase_resp_cycle: got %0d expected 10", first_resp_cycle); end
  endtask

  task automatic test_bias_horizontal();
    bit got;
    logic signed [ACC_W-1:0] red;
    fill_mem(0);
    send_request(0, 0, 9, 0, 3);
    wait_resp(got);
    tests_run++;
    if (!got) begin tests_failed++; $display("[TB] FAIL bias_timeout: got no resp_val expected one"); do_reset(); return; end
    red = resp_reduction;
    tests_run++;
    if (red !== -19'sd160 || resp_count !== 10'd10) begin
      tests_failed++; $display("[TB] FAIL bias_resp: got red=%0d cnt=%0d expected -160/10", red, resp_count);
    end
    handshake();
    tests_run++;
    if (first_resp_cycle != 13 || wen_cnt != 0) begin
      tests_failed++; $display("[TB] FAIL bias_timing: got cycle=%0d writes=%0d expected 13/0", first_resp_cycle, wen_cnt);
    end
  endtask

  task automatic test_bounds();
    bit got;
    send_request(0, 0, 320, 0, 0);
    wait_resp(got);
    tests_run++;
    if (!got) begin tests_failed++; $display("[TB] FAIL bounds_timeout: got no resp_val expected one"); do_reset(); return; end
    tests_run++;
    if (resp_err !== 1'b1 || resp_count !== '0 || resp_reduction !== '0) begin
      tests_failed++;
      $display("[TB] FAIL bounds_resp: got err=%b cnt=%0d red=%0d expected 1/0/0", resp_err, resp_count, resp_reduction);
    end
    handshake();
    tests_run++;
    if (ren_cnt != 0 || wen_cnt != 0 || first_resp_cycle != 2) begin
      tests_failed++;
      $display("[TB] FAIL bounds_x_access: got ren=%0d wen=%0d cycle=%0d expected 0/0/2", ren_cnt, wen_cnt, first_resp_cycle);
    end
    send_request(0, 320, 0, 0, 1);
    wait_resp(got);
    tests_run++;
    if (!got || resp_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL bounds_y_err: got val=%b err=%b expected 1/1", got, resp_err); end
    if (got) handshake(); else do_reset();
    tests_run++;
    if (ren_cnt != 0 || wen_cnt != 0) begin
      tests_failed++; $display("[TB] FAIL bounds_y_access: got ren=%0d wen=%0d expected 0/0", ren_cnt, wen_cnt);
    end
  endtask

  task automatic test_resp_hold();
    bit got;
    fill_mem(7);
    send_request(0, 0, 3, 0, 0);
    wait_resp(got);
    tests_run++;
    if (!got) begin tests_failed++; $display("[TB] FAIL hold_timeout: got no resp_val expected one"); do_reset(); return; end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (resp_val !== 1'b1 || resp_reduction !== 19'd28 || resp_count !== 10'd4 || resp_err !== 1'b0 || req_rdy !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL hold_stable: cycle %0d got val=%b red=%0d cnt=%0d err=%b rdy=%b expected 1/28/4/0/0",
                 c, resp_val, resp_reduction, resp_count, resp_err, req_rdy);
      end
    end
    handshake();
    @(negedge clk);
    tests_run++;
    if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL hold_release: got rdy=%b val=%b expected 1/0", req_rdy, resp_val);
    end
  endtask

  task automatic test_back_to_back();
    bit got;
    logic signed [ACC_W-1:0] red;
    fill_mem(7);
    send_request(0, 20, 5, 20, 0);
    req_x0 = 9'd0; req_y0 = 9'd30; req_x1 = 9'd0; req_y1 = 9'd30; req_mode = 2'd2;
    req_val = 1'b1;
    repeat (3) @(posedge clk);
    #1 req_val = 1'b0;
    wait_resp(got);
    tests_run++;
    if (!got) begin tests_failed++; $display("[TB] FAIL b2b_timeout: got no resp_val expected one"); do_reset(); return; end
    tests_run++;
    if (resp_reduction !== 19'd42 || resp_count !== 10'd6) begin
      tests_failed++; $display("[TB] FAIL b2b_first: got red=%0d cnt=%0d expected 42/6", resp_reduction, resp_count);
    end
    handshake();
    tests_run++;
    if (wen_cnt != 0) begin tests_failed++; $display("[TB] FAIL b2b_busy_ignored: got %0d writes expected 0", wen_cnt); end
    clear_stats();
    req_val = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
    wait_resp(got);
    tests_run++;
    if (!got) begin tests_failed++; $display("[TB] FAIL b2b_second_timeout: got no resp_val expected one"); do_reset(); return; end
    red = resp_reduction;
    tests_run++;
    if (red !== -19'sd7 || resp_count !== 10'd1) begin
      tests_failed++; $display("[TB] FAIL b2b_second: got red=%0d cnt=%0d expected -7/1", red, resp_count);
    end
    tests_run++;
    if (accept_edge != hs_edge + 1) begin
      tests_failed++; $display("[TB] FAIL b2b_accept_edge: got %0d expected %0d", accept_edge, hs_edge + 1);
    end
    handshake();
    tests_run++;
    if (mem[30 * 320] !== 8'd39 || wen_cnt != 1) begin
      tests_failed++; $display("[TB] FAIL b2b_write: got mem=%0d writes=%0d expected 39/1", mem[30 * 320], wen_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    fill_mem(100);
    send_request(0, 0, 50, 0, 1);
    repeat (10) @(posedge clk);
    #1;
    tests_run++;
    if (wen_cnt == 0) begin tests_failed++; $display("[TB] FAIL midreset_started: got 0 writes expected some"); end
    reset = 1'b1;
    @(posedge clk); #1;
    clear_stats();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    tests_run++;
    if (ren_cnt != 0 || wen_cnt != 0 || first_resp_cycle != -1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_quiet: got ren=%0d wen=%0d resp_cycle=%0d expected 0/0/-1", ren_cnt, wen_cnt, first_resp_cycle);
    end
    tests_run++;
    if (req_rdy !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_rdy: got %b expected 1", req_rdy); end
    send_request(0, 10, 2, 10, 0);
    wait_resp(got);
    tests_run++;
    if (!got || resp_reduction !== 19'd300 || resp_count !== 10'd3) begin
      tests_failed++;
      $display("[TB] FAIL midreset_recover: got val=%b red=%0d cnt=%0d expected 1/300/3", got, resp_reduction, resp_count);
    end
    if (got) handshake(); else do_reset();
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_score_diag();
    test_draw_point();
    test_erase_vertical();
    test_bias_horizontal();
    test_bounds();
    test_resp_hold();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
